branch_exec: RTL and testbench

Branch execution unit sitting directly downstream of the branch reservation station. Watches the station's single entry, accepts it once both operand tags are unlocked, and resolves the condition and next PC. It then hands the redirect to fetch and the link value (JAL/JALR) to writeback, each over a valid/ready handshake. It drives `busy_branch` back to the station so the entry is retired exactly once.

---
 rtl/branch_exec_pkg.sv | 38 +++
 rtl/branch_exec_cmp.sv | 55 +++++
 rtl/branch_exec.sv | 154 +++++++++++++++
 tb/tb_branch_exec.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_exec_pkg.sv
// Shared types and encodings for the branch execution unit: word/tag/op types,
// branch op codes, the UNLOCKED tag marker and the FSM state encoding.
package branch_exec_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int OP_W  = 6;
  localparam int RA_W  = 5;

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [XLEN-1:0]  addr_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [OP_W-1:0]  sinst_t;
  typedef logic [RA_W-1:0]  regaddr_t;

  localparam tag_t     UNLOCKED = '1;
  localparam regaddr_t ZERO     = '0;

  // Encoding 0 and everything above JALR are unknown ops.
  localparam sinst_t OP_BEQ  = 6'd1;
  localparam sinst_t OP_BNE  = 6'd2;
  localparam sinst_t OP_BLT  = 6'd3;
  localparam sinst_t OP_BGE  = 6'd4;
  localparam sinst_t OP_BLTU = 6'd5;
  localparam sinst_t OP_BGEU = 6'd6;
  localparam sinst_t OP_JAL  = 6'd7;
  localparam sinst_t OP_JALR = 6'd8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  function automatic logic is_jump(input sinst_t op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/branch_exec_cmp.sv
// Combinational branch resolution: condition evaluation, next PC and link value.
module branch_cmp
  import branch_exec_pkg::*;
#(
  parameter int XLEN = branch_exec_pkg::XLEN,
  parameter int RA_W = branch_exec_pkg::RA_W
) (
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] offset_i,
  input  logic [XLEN-1:0] x_i,
  input  logic [XLEN-1:0] y_i,
  input  logic [RA_W-1:0] rd_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic [XLEN-1:0] link_data_o,
  output logic            link_pend_o
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] target_pc;
  logic [XLEN-1:0] jalr_sum;
  logic            eq;
  logic            lt;
  logic            ltu;
  logic            taken;

  assign seq_pc    = pc_i + XLEN'(4);
  assign target_pc = pc_i + offset_i;
  assign jalr_sum  = x_i + offset_i;
  assign eq        = (x_i == y_i);
  assign lt        = ($signed(x_i) < $signed(y_i));
  assign ltu       = (x_i < y_i);

  always_comb begin
    taken = 1'b0;
    unique case (op_i)
      OP_BEQ:  taken = eq;
      OP_BNE:  taken = !eq;
      OP_BLT:  taken = lt;
      OP_BGE:  taken = !lt;
      OP_BLTU: taken = ltu;
      OP_BGEU: taken = !ltu;
      OP_JAL:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // JALR targets are register-relative and always halfword aligned.
  assign next_pc_o   = (op_i == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                     : taken             ? target_pc
                     :                     seq_pc;
  assign link_data_o = seq_pc;
  assign link_pend_o = is_jump(op_i) && (rd_i != '0);

endmodule

// File: rtl/branch_exec.sv
// Branch execution unit: accepts the reservation-station entry once both tags
// are unlocked, resolves it, then hands redirect and link writeback downstream.
module branch_exec
  import branch_exec_pkg::*;
#(
  parameter int XLEN  = branch_exec_pkg::XLEN,
  parameter int TAG_W = branch_exec_pkg::TAG_W,
  parameter int RA_W  = branch_exec_pkg::RA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rs_busy,
  input  logic [XLEN-1:0]  rs_pc,
  input  logic [XLEN-1:0]  rs_offset,
  input  logic [OP_W-1:0]  rs_op,
  input  logic [TAG_W-1:0] rs_tagx,
  input  logic [TAG_W-1:0] rs_tagy,
  input  logic [XLEN-1:0]  rs_datax,
  input  logic [XLEN-1:0]  rs_datay,
  input  logic [RA_W-1:0]  rs_rd,
  output logic             busy_branch,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             wb_valid,
  output logic [RA_W-1:0]  wb_rd,
  output logic [XLEN-1:0]  wb_data,
  input  logic             wb_ready
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] off_q, off_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0] x_q, x_d;
  logic [XLEN-1:0] y_q, y_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [RA_W-1:0] wb_rd_q, wb_rd_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic            wb_valid_q, wb_valid_d;

  logic [XLEN-1:0] cmp_next_pc;
  logic [XLEN-1:0] cmp_link_data;
  logic            cmp_link_pend;
  logic            can_accept;

  branch_cmp #(.XLEN(XLEN), .RA_W(RA_W)) u_cmp (
    .op_i        (op_q),
    .pc_i        (pc_q),
    .offset_i    (off_q),
    .x_i         (x_q),
    .y_i         (y_q),
    .rd_i        (rd_q),
    .next_pc_o   (cmp_next_pc),
    .link_data_o (cmp_link_data),
    .link_pend_o (cmp_link_pend)
  );

  assign can_accept = rs_busy && (rs_tagx == {TAG_W{1'b1}}) && (rs_tagy == {TAG_W{1'b1}});

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    off_d            = off_q;
    op_d             = op_q;
    x_d              = x_q;
    y_d              = y_q;
    rd_d             = rd_q;
    redirect_pc_d    = redirect_pc_q;
    wb_data_d        = wb_data_q;
    wb_rd_d          = wb_rd_q;
    redirect_valid_d = redirect_valid_q;
    wb_valid_d       = wb_valid_q;
    // With rdy low nothing moves and no handshake is taken.
    if (rdy) begin
      unique case (state_q)
        ST_IDLE: begin
          if (can_accept) begin
            pc_d    = rs_pc;
            off_d   = rs_offset;
            op_d    = rs_op;
            x_d     = rs_datax;
            y_d     = rs_datay;
            rd_d    = rs_rd;
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          redirect_pc_d    = cmp_next_pc;
          wb_data_d        = cmp_link_data;
          wb_rd_d          = rd_q;
          redirect_valid_d = 1'b1;
          wb_valid_d       = cmp_link_pend;
          state_d          = ST_RESP;
        end
        ST_RESP: begin
          if (redirect_valid_q && redirect_ready) redirect_valid_d = 1'b0;
          if (wb_valid_q && wb_ready)             wb_valid_d       = 1'b0;
          if (!redirect_valid_d && !wb_valid_d)   state_d          = ST_DRAIN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      pc_q             <= '0;
      off_q            <= '0;
      op_q             <= '0;
      x_q              <= '0;
      y_q              <= '0;
      rd_q             <= '0;
      redirect_pc_q    <= '0;
      wb_data_q        <= '0;
      wb_rd_q          <= '0;
      redirect_valid_q <= 1'b0;
      wb_valid_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      off_q            <= off_d;
      op_q             <= op_d;
      x_q              <= x_d;
      y_q              <= y_d;
      rd_q             <= rd_d;
      redirect_pc_q    <= redirect_pc_d;
      wb_data_q        <= wb_data_d;
      wb_rd_q          <= wb_rd_d;
      redirect_valid_q <= redirect_valid_d;
      wb_valid_q       <= wb_valid_d;
    end
  end

  // DRAIN drops busy for one cycle so the station retires its entry.
  always_comb begin
    unique case (state_q)
      ST_IDLE:  busy_branch = rs_busy;
      ST_DRAIN: busy_branch = 1'b0;
      default:  busy_branch = 1'b1;
    endcase
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;

endmodule

// File: tb/tb_branch_exec.sv
// Directed bench for branch_exec: expected responses queued at issue, popped and
// compared when the unit presents them in RESP.
module tb_branch_exec;
  import branch_exec_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic        wv;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  localparam logic [3:0] LOCKED = 4'h2;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rs_busy;
  logic [31:0] rs_pc;
  logic [31:0] rs_offset;
  logic [5:0]  rs_op;
  logic [3:0]  rs_tagx;
  logic [3:0]  rs_tagy;
  logic [31:0] rs_datax;
  logic [31:0] rs_datay;
  logic [4:0]  rs_rd;
  logic        busy_branch;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  branch_exec dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rs_busy        (rs_busy),
    .rs_pc          (rs_pc),
    .rs_offset      (rs_offset),
    .rs_op          (rs_op),
    .rs_tagx        (rs_tagx),
    .rs_tagy        (rs_tagy),
    .rs_datax       (rs_datax),
    .rs_datay       (rs_datay),
    .rs_rd          (rs_rd),
    .busy_branch    (busy_branch),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_ready       (wb_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [5:0] op, input logic [31:0] pc,
                                 input logic [31:0] off, input logic [31:0] x,
                                 input logic [31:0] y, input logic [4:0] rd);
    exp_t e;
    logic [31:0] t;
    e.pc   = pc + 32'd4;
    e.data = pc + 32'd4;
    e.rd   = rd;
    e.wv   = 1'b0;
    case (op)
      OP_BEQ:  if (x == y) e.pc = pc + off;
      OP_BNE:  if (x != y) e.pc = pc + off;
      OP_BLT:  if ($signed(x) < $signed(y)) e.pc = pc + off;
      OP_BGE:  if ($signed(x) >= $signed(y)) e.pc = pc + off;
      OP_BLTU: if (x < y) e.pc = pc + off;
      OP_BGEU: if (x >= y) e.pc = pc + off;
      OP_JAL: begin
        e.pc = pc + off;
        e.wv = (rd != 5'd0);
      end
      OP_JALR: begin
        t    = x + off;
        t[0] = 1'b0;
        e.pc = t;
        e.wv = (rd != 5'd0);
      end
      default: ;
    endcase
    return e;
  endfunction

  // Presents an entry with both tags unlocked; returns one cycle later in EXEC.
  task automatic issue(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] off,
                       input logic [31:0] x, input logic [31:0] y, input logic [4:0] rd);
    rs_op     = op;
    rs_pc     = pc;
    rs_offset = off;
    rs_datax  = x;
    rs_datay  = y;
    rs_rd     = rd;
    rs_tagx   = UNLOCKED;
    rs_tagy   = UNLOCKED;
    rs_busy   = 1'b1;
    sb.push_back(model(op, pc, off, x, y, rd));
    tick();
    // Entry stays visible but locked, so any re-accept would be a bug.
    rs_tagx = LOCKED;
    chk("exec_busy", busy_branch, 1);
    chk("exec_rv", redirect_valid, 0);
    chk("exec_wv", wb_valid, 0);
  endtask

  task automatic respond(input int rr_wait, input int wr_wait);
    exp_t e;
    bit   r_done;
    bit   w_done;
    int   c;
    tick();
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL sb_empty: observed=0 expected=1");
    end
    if (sb.size() == 0) return;
    e      = sb.pop_front();
    r_done = 1'b0;
    w_done = !e.wv;
    c      = 0;
    while (!(r_done && w_done) && c < 20) begin
      chk("resp_rv", redirect_valid, !r_done);
      chk("resp_wv", wb_valid, !w_done);
      chk("resp_busy", busy_branch, 1);
      if (!r_done) chk("redirect_pc", redirect_pc, e.pc);
      if (!w_done) begin
        chk("wb_data", wb_data, e.data);
        chk("wb_rd", wb_rd, e.rd);
      end
      redirect_ready = (c >= rr_wait);
      wb_ready       = (c >= wr_wait);
      tick();
      if (redirect_ready) r_done = 1'b1;
      if (wb_ready)       w_done = 1'b1;
      c++;
    end
    checks++;
    assert (c < 20) else begin
      errors++;
      $error("FAIL resp_timeout: observed=%0d expected<20", c);
    end
    redirect_ready = 1'b0;
    wb_ready       = 1'b0;
    chk("drain_busy", busy_branch, 0);
    chk("drain_rv", redirect_valid, 0);
    chk("drain_wv", wb_valid, 0);
    tick();
    chk("idle_busy", busy_branch, 1);
    tick();
    chk("idle_noacc_busy", busy_branch, 1);
    tick();
    chk("idle_noacc_rv", redirect_valid, 0);
    rs_busy = 1'b0;
    rs_tagx = UNLOCKED;
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; rdy = 1'b1; rs_busy = 1'b0;
    rs_pc = '0; rs_offset = '0; rs_op = '0; rs_rd = '0;
    rs_tagx = UNLOCKED; rs_tagy = UNLOCKED; rs_datax = '0; rs_datay = '0;
    redirect_ready = 1'b0; wb_ready = 1'b0;
    tick(); tick();
    chk("rst_rv", redirect_valid, 0);
    chk("rst_wv", wb_valid, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_wbrd", wb_rd, 0);
    chk("rst_busy0", busy_branch, 0);
    rs_busy = 1'b1; #1;
    chk("rst_busy1", busy_branch, 1);
    rs_busy = 1'b0;
    rst = 1'b1;
    tick();

    $display("step: BEQ taken");
    issue(OP_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 5'd3);
    respond(0, 0);

    $display("step: BLT signed taken");
    issue(OP_BLT, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 5'd0);
    respond(1, 0);

    $display("step: BLTU not taken");
    issue(OP_BLTU, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 5'd0);
    respond(0, 0);

    $display("step: BGE / BNE / BGEU");
    issue(OP_BGE, 32'h300, 32'h10, 32'd7, 32'hFFFF_FFF0, 5'd0);
    respond(0, 0);
    issue(OP_BNE, 32'h300, 32'h10, 32'd7, 32'd7, 5'd0);
    respond(0, 0);
    issue(OP_BGEU, 32'h300, 32'hFFFF_FFF0, 32'd9, 32'd9, 5'd0);
    respond(0, 0);

    $display("step: JALR with delayed writeback");
    issue(OP_JALR, 32'h40, 32'd4, 32'h2003, 32'd0, 5'd1);
    respond(0, 3);

    $display("step: JAL rd=0 wrap");
    issue(OP_JAL, 32'hFFFF_FFFC, 32'd8, 32'd0, 32'd0, 5'd0);
    respond(0, 0);

    $display("step: unknown op");
    issue(6'h3F, 32'h500, 32'h80, 32'd1, 32'd1, 5'd4);
    respond(0, 0);

    $display("step: tag wait");
    rs_op = OP_BEQ; rs_pc = 32'h600; rs_offset = 32'h8; rs_datax = 32'd1;
    rs_datay = 32'd1; rs_rd = 5'd0; rs_tagx = UNLOCKED; rs_tagy = LOCKED; rs_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("wait_busy", busy_branch, 1);
      chk("wait_rv", redirect_valid, 0);
      tick();
    end
    rs_tagy = UNLOCKED;
    sb.push_back(model(OP_BEQ, 32'h600, 32'h8, 32'd1, 32'd1, 5'd0));
    tick();
    rs_tagx = LOCKED;
    chk("wait_exec_rv", redirect_valid, 0);
    respond(0, 0);

    $display("step: freeze and reset");
    issue(OP_JALR, 32'h80, 32'h10, 32'h1000, 32'd0, 5'd2);
    tick();
    e = sb.pop_front();
    chk("frz_rv", redirect_valid, 1);
    chk("frz_wv", wb_valid, e.wv);
    chk("frz_rpc", redirect_pc, e.pc);
    rdy = 1'b0; redirect_ready = 1'b1; wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_hold_rv", redirect_valid, 1);
      chk("frz_hold_wv", wb_valid, 1);
      chk("frz_hold_rpc", redirect_pc, e.pc);
      chk("frz_hold_wbdata", wb_data, e.data);
    end
    rdy = 1'b1;
    tick();
    chk("unfrz_rv", redirect_valid, 0);
    chk("unfrz_wv", wb_valid, 1);
    redirect_ready = 1'b0;
    rs_busy = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_rv", redirect_valid, 0);
    chk("arst_wv", wb_valid, 0);
    chk("arst_rpc", redirect_pc, 0);
    chk("arst_wbdata", wb_data, 0);
    chk("arst_wbrd", wb_rd, 0);
    chk("arst_busy", busy_branch, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_busy", busy_branch, 0);
    chk("post_rst_rv", redirect_valid, 0);

    $display("step: post-reset BNE taken");
    issue(OP_BNE, 32'h700, 32'hFFFF_FF00, 32'd1, 32'd2, 5'd0);
    respond(2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
